ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage; consumes the decoder's operation bundle (rtlop, rtltype, pc, src1, src2, gprs_waddr) through a valid/ready handshake.
- Computes the arithmetic/logic result and registers a write-back bundle.
- Drives the same-cycle forwarding pair back to the decoder.
- Shifts use an iterative 1-bit-per-cycle shifter, which stalls the decoder while it runs.

Parameters:
DATA_W, 32, operand/result width
REG_W, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_i  in  1  decoder bundle valid
ready_o  out  1  stage can accept bundle this cycle
rtlop_i  in  4  operation: 0000 ADD, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SHR, 0110 OR, 0111 AND, 1101 SAR
rtltype_i  in  2  00 = ARICH; other values invalid
pc_i  in  DATA_W  instruction PC (carried to write-back bundle)
src1_i  in  DATA_W  operand A (already forwarded by decoder)
src2_i  in  DATA_W  operand B, or immediate (SUB arrives pre-negated)
gprs_waddr_i  in  REG_W  destination register
ex_gprs_waddr  out  REG_W  forwarding address (combinational)
ex_gprs_wdata  out  DATA_W  forwarding data (combinational)
wb_we_o  out  1  write-back enable (registered)
wb_waddr_o  out  REG_W  write-back address (registered)
wb_wdata_o  out  DATA_W  write-back data (registered)
wb_pc_o  out  DATA_W  PC of the written instruction (registered)
error_o  out  1  one-cycle pulse for an invalid op (registered)

Behaviour:
- Reset: state IDLE; internal operand registers 0; all outputs listed as registered = 0; ex_gprs_waddr = 0.
- Reset mid-operation: the held op is discarded with no write-back and no error.
- States:
  - IDLE: no op held.
  - ALU: single-cycle op held.
  - SHIFT: shift op held; cnt = remaining steps.
- ready_o = (state==IDLE) || completing. Completing = ALU, or SHIFT with cnt==0.
- Accept: valid_i && ready_o at a clk edge. The edge latches rtlop, a=src1_i, b=src2_i, waddr, pc and cnt=src2_i[4:0].
  - Next state is SHIFT for rtlop 0001/0101/1101, else ALU.
  - Accept and complete in the same cycle is allowed, giving back-to-back throughput of 1 op/cycle.
- ALU results (all arithmetic modulo 2^DATA_W):
  - ADD: a+b, with carry discarded.
  - SLT: signed a<b gives 1, else 0.
  - SLTU: unsigned compare, same result encoding.
  - XOR, OR, AND: bitwise.
- SHIFT state, each cycle:
  - If cnt≠0: a<<=1 (SLL); a>>=1 with zero fill (SHR) or sign fill (SAR); cnt-=1; ready_o=0.
  - If cnt==0: complete with result=a.
  - Shift by 0 completes in the first SHIFT cycle with a unchanged.
  - Shift amount is b[4:0] only; b[31:5] is ignored (covers the SRAI immediate bit 10).
- Completion cycle (combinational):
  - ex_gprs_waddr=waddr and ex_gprs_wdata=result.
  - In all other cycles, ex_gprs_waddr=0 and ex_gprs_wdata=0.
- Completion edge (registered):
  - wb_we_o=(waddr≠0); wb_waddr_o=waddr; wb_wdata_o=result; wb_pc_o=pc.
  - Outputs hold their values; wb_we_o returns to 0 on the next edge unless another op completes.
- Invalid op: rtltype≠00, or rtlop not in the list above.
  - Detected at accept; the op is held one cycle as ALU.
  - At completion: error_o=1 for one cycle, wb_we_o=0, forwarding address 0.
- Latency from accept edge N:
  - ALU op: write-back at edge N+1.
  - Shift by k: write-back at edge N+1+k.
- valid_i while ready_o=0: the bundle is not taken; the upstream stage holds it.

Test Plan:
- ADD: src1=5, src2=0xFFFFFFFD (pre-negated 3), waddr=7 → forward addr 7 / data 2 in cycle N+1; wb_we=1, waddr=7, wdata=2 after edge N+1.
- SLT vs SLTU: a=0xFFFFFFFF, b=1 → SLT result 1, SLTU result 0; back-to-back issue with ready_o held at 1 for both.
- SAR: a=0x80000010, b=4 → ready_o low for 4 cycles; wdata=0xF8000001 at edge N+5. SHR on the same operands gives 0x08000001. Shift with b=0x20 (amount 0) completes next cycle with a unchanged.
- Destination x0: ADD with waddr=0 → wb_we=0; forwarding address stays 0.
- Invalid ops: rtltype=01, or rtlop=1000 → error_o pulses exactly one cycle, no write-back; the following valid ADD proceeds normally.
- Reset asserted during the 3rd cycle of a shift by 10 → no write-back, state IDLE, ready_o=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative 1-bit-per-cycle shifter,
// with same-cycle forwarding to the decoder and a registered write-back bundle.
module ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        rtlop_i,
    input  logic [1:0]        rtltype_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [REG_W-1:0]  gprs_waddr_i,
    output logic [REG_W-1:0]  ex_gprs_waddr,
    output logic [DATA_W-1:0] ex_gprs_wdata,
    output logic              wb_we_o,
    output logic [REG_W-1:0]  wb_waddr_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic [DATA_W-1:0] wb_pc_o,
    output logic              error_o
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_SAR  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE,
        ALU,
        SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [DATA_W-1:0]  opA_q, opA_d;
    logic [DATA_W-1:0]  opB_q, opB_d;
    logic [REG_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]  pc_q, pc_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               invalid_q, invalid_d;

    logic               wbWe_q, wbWe_d;
    logic [REG_W-1:0]   wbWaddr_q, wbWaddr_d;
    logic [DATA_W-1:0]  wbWdata_q, wbWdata_d;
    logic [DATA_W-1:0]  wbPc_q, wbPc_d;
    logic               error_q, error_d;

    logic               completing;
    logic               accept;
    logic               inOpValid;
    logic               inIsShift;
    logic [DATA_W-1:0]  result;

    assign completing = (state_q == ALU) || ((state_q == SHIFT) && (cnt_q == 5'd0));
    assign ready_o    = (state_q == IDLE) || completing;
    assign accept     = valid_i && ready_o;

    always_comb begin
        inIsShift = (rtlop_i == OP_SLL) || (rtlop_i == OP_SHR) || (rtlop_i == OP_SAR);
        inOpValid = 1'b0;
        if (rtltype_i == 2'b00) begin
            case (rtlop_i)
                OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
                OP_SHR, OP_OR, OP_AND, OP_SAR: inOpValid = 1'b1;
                default:                       inOpValid = 1'b0;
            endcase
        end
    end

    // Shift ops leave their final value in opA_q, so the default arm covers them.
    always_comb begin
        result = opA_q;
        case (op_q)
            OP_ADD:  result = opA_q + opB_q;
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(opA_q) < $signed(opB_q))};
            OP_SLTU: result = {{(DATA_W-1){1'b0}}, (opA_q < opB_q)};
            OP_XOR:  result = opA_q ^ opB_q;
            OP_OR:   result = opA_q | opB_q;
            OP_AND:  result = opA_q & opB_q;
            default: result = opA_q;
        endcase
    end

    always_comb begin
        ex_gprs_waddr = '0;
        ex_gprs_wdata = '0;
        if (completing && !invalid_q) begin
            ex_gprs_waddr = waddr_q;
            ex_gprs_wdata = result;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        waddr_d   = waddr_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        invalid_d = invalid_q;
        wbWe_d    = 1'b0;
        wbWaddr_d = wbWaddr_q;
        wbWdata_d = wbWdata_q;
        wbPc_d    = wbPc_q;
        error_d   = 1'b0;

        if ((state_q == SHIFT) && (cnt_q != 5'd0)) begin
            cnt_d = cnt_q - 5'd1;
            case (op_q)
                OP_SLL:  opA_d = {opA_q[DATA_W-2:0], 1'b0};
                OP_SAR:  opA_d = {opA_q[DATA_W-1], opA_q[DATA_W-1:1]};
                default: opA_d = {1'b0, opA_q[DATA_W-1:1]};
            endcase
        end

        if (completing) begin
            state_d = IDLE;
            if (invalid_q) begin
                error_d = 1'b1;
            end else begin
                wbWe_d    = (waddr_q != '0);
                wbWaddr_d = waddr_q;
                wbWdata_d = result;
                wbPc_d    = pc_q;
            end
        end

        // A new bundle may be taken on the same edge the held op completes.
        if (accept) begin
            op_d      = rtlop_i;
            opA_d     = src1_i;
            opB_d     = src2_i;
            waddr_d   = gprs_waddr_i;
            pc_d      = pc_i;
            cnt_d     = src2_i[4:0];
            invalid_d = !inOpValid;
            state_d   = (inOpValid && inIsShift) ? SHIFT : ALU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            opA_q     <= '0;
            opB_q     <= '0;
            waddr_q   <= '0;
            pc_q      <= '0;
            cnt_q     <= '0;
            invalid_q <= 1'b0;
            wbWe_q    <= 1'b0;
            wbWaddr_q <= '0;
            wbWdata_q <= '0;
            wbPc_q    <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            waddr_q   <= waddr_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            invalid_q <= invalid_d;
            wbWe_q    <= wbWe_d;
            wbWaddr_q <= wbWaddr_d;
            wbWdata_q <= wbWdata_d;
            wbPc_q    <= wbPc_d;
            error_q   <= error_d;
        end
    end

    assign wb_we_o    = wbWe_q;
    assign wb_waddr_o = wbWaddr_q;
    assign wb_wdata_o = wbWdata_q;
    assign wb_pc_o    = wbPc_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver queues hand-computed write-back
// records; an independent monitor pops and compares them whenever the DUT writes back or flags an error.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [3:0]  rtlop_i = '0;
    logic [1:0]  rtltype_i = '0;
    logic [31:0] pc_i = '0;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic [4:0]  gprs_waddr_i = '0;
    logic [4:0]  ex_gprs_waddr;
    logic [31:0] ex_gprs_wdata;
    logic        wb_we_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic [31:0] wb_pc_o;
    logic        error_o;

    ex_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .rtlop_i      (rtlop_i),
        .rtltype_i    (rtltype_i),
        .pc_i         (pc_i),
        .src1_i       (src1_i),
        .src2_i       (src2_i),
        .gprs_waddr_i (gprs_waddr_i),
        .ex_gprs_waddr(ex_gprs_waddr),
        .ex_gprs_wdata(ex_gprs_wdata),
        .wb_we_o      (wb_we_o),
        .wb_waddr_o   (wb_waddr_o),
        .wb_wdata_o   (wb_wdata_o),
        .wb_pc_o      (wb_pc_o),
        .error_o      (error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc;
        int          cycle;
    } wbExp_t;

    wbExp_t expQ[$];
    wbExp_t monExp;
    int     cycle = 0;
    int     checks = 0;
    int     errors = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Drive one bundle, hold it until accepted, and queue its expected write-back.
    task automatic applyStimulus(input logic [3:0] op, input logic [1:0] ty, input logic [31:0] pc,
                                 input logic [31:0] s1, input logic [31:0] s2, input logic [4:0] wa,
                                 input bit doPush, input bit isErr, input logic [31:0] expData,
                                 input int lat, output int acceptEdge);
        int waited;
        wbExp_t e;
        @(negedge clk);
        rtlop_i = op; rtltype_i = ty; pc_i = pc; src1_i = s1; src2_i = s2; gprs_waddr_i = wa;
        valid_i = 1'b1;
        waited = 0;
        while (!ready_o && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept timeout: ready_o=0 after %0d cycles, expected 1", waited);
            valid_i = 1'b0;
            acceptEdge = -1;
            return;
        end
        acceptEdge = cycle + 1;
        if (doPush) begin
            e.err = isErr; e.waddr = wa; e.wdata = expData; e.pc = pc; e.cycle = acceptEdge + lat;
            expQ.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idleCycle();
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && (wb_we_o || error_o)) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected wb: we=%0b err=%0b waddr=%0d wdata=0x%08h, expected none",
                         wb_we_o, error_o, wb_waddr_o, wb_wdata_o);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("wb cycle", cycle, monExp.cycle);
                checkOutput("error_o", {31'b0, error_o}, {31'b0, monExp.err});
                checkOutput("wb_we_o", {31'b0, wb_we_o}, {31'b0, !monExp.err});
                if (!monExp.err) begin
                    checkOutput("wb_waddr_o", {27'b0, wb_waddr_o}, {27'b0, monExp.waddr});
                    checkOutput("wb_wdata_o", wb_wdata_o, monExp.wdata);
                    checkOutput("wb_pc_o", wb_pc_o, monExp.pc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n1, n2, lowCnt, waited;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset wb_we_o", {31'b0, wb_we_o}, 32'd0);
        checkOutput("reset wb_wdata_o", wb_wdata_o, 32'd0);
        checkOutput("reset wb_pc_o", wb_pc_o, 32'd0);
        checkOutput("reset error_o", {31'b0, error_o}, 32'd0);
        checkOutput("reset ready_o", {31'b0, ready_o}, 32'd1);
        checkOutput("reset ex_gprs_waddr", {27'b0, ex_gprs_waddr}, 32'd0);
        rst = 1'b0;

        // ADD with pre-negated operand, plus forwarding in the completion cycle
        applyStimulus(4'b0000, 2'b00, 32'h100, 32'd5, 32'hFFFF_FFFD, 5'd7, 1, 0, 32'd2, 1, n1);
        idleCycle();
        checkOutput("fwd addr ADD", {27'b0, ex_gprs_waddr}, 32'd7);
        checkOutput("fwd data ADD", ex_gprs_wdata, 32'd2);
        idleCycle();
        checkOutput("fwd addr idle", {27'b0, ex_gprs_waddr}, 32'd0);

        // SLT then SLTU back to back
        applyStimulus(4'b0010, 2'b00, 32'h104, 32'hFFFF_FFFF, 32'd1, 5'd3, 1, 0, 32'd1, 1, n1);
        applyStimulus(4'b0011, 2'b00, 32'h108, 32'hFFFF_FFFF, 32'd1, 5'd4, 1, 0, 32'd0, 1, n2);
        checkOutput("back-to-back accept", n2, n1 + 1);
        applyStimulus(4'b0100, 2'b00, 32'h10C, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd10, 1, 0, 32'hFF00_EDCB, 1, n1);
        applyStimulus(4'b0110, 2'b00, 32'h110, 32'hF0F0_0000, 32'h0000_1234, 5'd11, 1, 0, 32'hF0F0_1234, 1, n1);
        applyStimulus(4'b0111, 2'b00, 32'h114, 32'hF0F0_1234, 32'h0FF0_00FF, 5'd12, 1, 0, 32'h00F0_0034, 1, n1);
        idleCycle();

        // SAR by 4: ready_o low for four cycles
        applyStimulus(4'b1101, 2'b00, 32'h200, 32'h8000_0010, 32'd4, 5'd5, 1, 0, 32'hF800_0001, 5, n1);
        idleCycle();
        lowCnt = 0;
        waited = 0;
        while (!ready_o && waited < 50) begin
            lowCnt++;
            @(negedge clk);
            waited++;
        end
        checkOutput("SAR ready_o low cycles", lowCnt, 32'd4);
        applyStimulus(4'b0101, 2'b00, 32'h204, 32'h8000_0010, 32'd4, 5'd5, 1, 0, 32'h0800_0001, 5, n1);
        idleCycle();
        applyStimulus(4'b0001, 2'b00, 32'h208, 32'h1234_5678, 32'h20, 5'd8, 1, 0, 32'h1234_5678, 1, n1);
        applyStimulus(4'b0001, 2'b00, 32'h20C, 32'h0000_0003, 32'h0000_0402, 5'd9, 1, 0, 32'h0000_000C, 3, n1);
        idleCycle();

        // Destination x0: no write-back, forwarding address stays 0
        applyStimulus(4'b0000, 2'b00, 32'h300, 32'd1, 32'd1, 5'd0, 0, 0, 32'd0, 1, n1);
        idleCycle();
        checkOutput("x0 fwd addr", {27'b0, ex_gprs_waddr}, 32'd0);
        idleCycle();
        checkOutput("x0 wb_we_o", {31'b0, wb_we_o}, 32'd0);

        // Invalid ops, then a normal ADD
        applyStimulus(4'b0000, 2'b01, 32'h400, 32'd1, 32'd2, 5'd13, 1, 1, 32'd0, 1, n1);
        applyStimulus(4'b1000, 2'b00, 32'h404, 32'd1, 32'd2, 5'd14, 1, 1, 32'd0, 1, n1);
        applyStimulus(4'b0000, 2'b00, 32'h408, 32'd10, 32'd20, 5'd9, 1, 0, 32'd30, 1, n1);
        idleCycle();
        idleCycle();

        // Reset during the third cycle of a shift by 10
        applyStimulus(4'b0001, 2'b00, 32'h500, 32'd1, 32'd10, 5'd6, 0, 0, 32'd0, 11, n1);
        idleCycle();
        idleCycle();
        idleCycle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset ready_o", {31'b0, ready_o}, 32'd1);
        checkOutput("post-reset wb_we_o", {31'b0, wb_we_o}, 32'd0);
        repeat (14) idleCycle();

        waited = 0;
        while (expQ.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("scoreboard drained", expQ.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
